// File: rtl/scalar_program_counter_pkg.sv
// Shared encodings for the scalar ALU program counter.
package scalar_pc_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD       = 3'd0;
  localparam logic [OP_W-1:0] OP_INC        = 3'd1;
  localparam logic [OP_W-1:0] OP_SET        = 3'd2;
  localparam logic [OP_W-1:0] OP_BRANCH_REL = 3'd3;
  localparam logic [OP_W-1:0] OP_CALL       = 3'd4;
  localparam logic [OP_W-1:0] OP_RET        = 3'd5;
endpackage

// File: rtl/scalar_program_counter_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = PTR_W'(0) + (PTR_W+1)'(DEPTH);

  logic [W-1:0]     entry [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] wp_dec;

  assign wp_dec = wp - 1'b1;
  assign top    = entry[wp_dec];
  assign full   = (count == CNT_MAX);
  assign empty  = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wp    <= wp_dec;
      count <= count - 1'b1;
    end
  end

  // Entry contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clock) begin
    if (push) entry[wp] <= push_data;
  end
endmodule

// File: rtl/scalar_program_counter.sv
// Program counter with hold/inc/set/branch/call/ret for the scalar ALU front end.
// Define PC_STACK_ERR_EN to add the sticky RS_ERR overflow/underflow flag.
module scalar_program_counter
  import scalar_pc_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int          STEP     = 4,
  parameter int          OFF_W    = 8,
  parameter int          RS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        STALL,
  input  logic [OP_W-1:0]             PC_OP,
  input  logic [PC_W-1:0]             PC_IN,
  input  logic [OFF_W-1:0]            PC_OFF,
  output logic [PC_W-1:0]             PC_OUT,
  output logic [PC_W-1:0]             PC_NEXT,
  output logic [$clog2(RS_DEPTH):0]   RS_COUNT,
  output logic                        RS_FULL,
`ifdef PC_STACK_ERR_EN
  output logic                        RS_ERR,
`endif
  output logic                        RS_EMPTY
);
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] rs_top;
  logic            push;
  logic            pop;

  assign pc_inc = PC_OUT + PC_W'(STEP);
  assign push   = !STALL && (PC_OP == OP_CALL);
  assign pop    = !STALL && (PC_OP == OP_RET);

  always_comb begin
    off_ext              = {PC_W{PC_OFF[OFF_W-1]}};
    off_ext[OFF_W-1:0]   = PC_OFF;
  end

  always_comb begin
    PC_NEXT = PC_OUT;
    if (!STALL) begin
      case (PC_OP)
        OP_INC:        PC_NEXT = pc_inc;
        OP_SET:        PC_NEXT = PC_IN;
        OP_BRANCH_REL: PC_NEXT = PC_OUT + off_ext;
        OP_CALL:       PC_NEXT = PC_IN;
        // An empty stack degrades RET to a sequential step.
        OP_RET:        PC_NEXT = RS_EMPTY ? pc_inc : rs_top;
        default:       PC_NEXT = PC_OUT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) PC_OUT <= RESET_PC;
    else       PC_OUT <= PC_NEXT;
  end

  pc_return_stack #(
    .DEPTH (RS_DEPTH),
    .W     (PC_W)
  ) u_rs (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (rs_top),
    .count     (RS_COUNT),
    .full      (RS_FULL),
    .empty     (RS_EMPTY)
  );

`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  RS_ERR <= 1'b0;
    else if ((push && RS_FULL) || (pop && RS_EMPTY)) RS_ERR <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_scalar_program_counter.sv
// Directed-vector bench for scalar_program_counter (RESET_PC = 0x10, RS_DEPTH = 4).
module tb_scalar_program_counter;
  import scalar_pc_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       STALL;
  logic [2:0] PC_OP;
  logic [7:0] PC_IN;
  logic [7:0] PC_OFF;
  logic [7:0] PC_OUT;
  logic [7:0] PC_NEXT;
  logic [2:0] RS_COUNT;
  logic       RS_FULL;
  logic       RS_EMPTY;
`ifdef PC_STACK_ERR_EN
  logic       RS_ERR;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  scalar_program_counter #(
    .PC_W(8), .STEP(4), .OFF_W(8), .RS_DEPTH(4), .RESET_PC(8'h10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .STALL    (STALL),
    .PC_OP    (PC_OP),
    .PC_IN    (PC_IN),
    .PC_OFF   (PC_OFF),
    .PC_OUT   (PC_OUT),
    .PC_NEXT  (PC_NEXT),
    .RS_COUNT (RS_COUNT),
    .RS_FULL  (RS_FULL),
`ifdef PC_STACK_ERR_EN
    .RS_ERR   (RS_ERR),
`endif
    .RS_EMPTY (RS_EMPTY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one op, cross a rising edge, and settle just after it.
  task automatic step(input logic [2:0] op, input logic [7:0] in, input logic [7:0] off);
    PC_OP  = op;
    PC_IN  = in;
    PC_OFF = off;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; STALL = 1'b0; PC_OP = OP_HOLD; PC_IN = '0; PC_OFF = '0;
    #12;
    check("rst_pc",    32'(PC_OUT),   32'h10);
    check("rst_cnt",   32'(RS_COUNT), 32'd0);
    check("rst_empty", 32'(RS_EMPTY), 32'd1);
    check("rst_full",  32'(RS_FULL),  32'd0);
    @(negedge clock); reset = 1'b0;

    PC_OP = OP_INC; #1;
    check("next_inc", 32'(PC_NEXT), 32'h14);
    step(OP_INC, 8'h00, 8'h00); check("inc1", 32'(PC_OUT), 32'h14);
    step(OP_INC, 8'h00, 8'h00); check("inc2", 32'(PC_OUT), 32'h18);
    step(OP_INC, 8'h00, 8'h00); check("inc3", 32'(PC_OUT), 32'h1C);

    STALL = 1'b1;
    step(OP_SET, 8'h99, 8'h00); check("stall1", 32'(PC_OUT), 32'h1C);
    check("stall_next", 32'(PC_NEXT), 32'h1C);
    step(OP_CALL, 8'h99, 8'h00); check("stall2", 32'(PC_OUT), 32'h1C);
    check("stall_cnt", 32'(RS_COUNT), 32'd0);
    STALL = 1'b0;

    step(OP_SET, 8'hFC, 8'h00);        check("set_fc", 32'(PC_OUT), 32'hFC);
    step(OP_INC, 8'h00, 8'h00);        check("wrap",   32'(PC_OUT), 32'h00);
    step(OP_SET, 8'h40, 8'h00);        check("set_40", 32'(PC_OUT), 32'h40);
    step(OP_BRANCH_REL, 8'h00, 8'hF8); check("br_neg", 32'(PC_OUT), 32'h38);
    step(OP_BRANCH_REL, 8'h00, 8'h7F); check("br_pos", 32'(PC_OUT), 32'hB7);
    step(3'd6, 8'h12, 8'h34);          check("rsvd6",  32'(PC_OUT), 32'hB7);
    step(3'd7, 8'h12, 8'h34);          check("rsvd7",  32'(PC_OUT), 32'hB7);

    step(OP_SET, 8'h20, 8'h00);
    step(OP_CALL, 8'h80, 8'h00); check("call1_pc", 32'(PC_OUT), 32'h80); check("call1_cnt", 32'(RS_COUNT), 32'd1);
    step(OP_CALL, 8'hA0, 8'h00); check("call2_pc", 32'(PC_OUT), 32'hA0); check("call2_cnt", 32'(RS_COUNT), 32'd2);
    PC_OP = OP_RET; #1; check("next_ret", 32'(PC_NEXT), 32'h84);
    step(OP_RET, 8'h00, 8'h00);  check("ret1_pc",  32'(PC_OUT), 32'h84); check("ret1_cnt",  32'(RS_COUNT), 32'd1);
    step(OP_RET, 8'h00, 8'h00);  check("ret2_pc",  32'(PC_OUT), 32'h24); check("ret2_cnt",  32'(RS_COUNT), 32'd0);

    // Overflow: five nested calls into a four-deep stack.
    step(OP_SET, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(OP_CALL, 8'((i + 1) * 16), 8'h00);
      check("ovf_pc", 32'(PC_OUT), 32'((i + 1) * 16));
`ifdef PC_STACK_ERR_EN
      check("ovf_err", 32'(RS_ERR), (i == 4) ? 32'd1 : 32'd0);
`endif
    end
    check("ovf_full", 32'(RS_FULL),  32'd1);
    check("ovf_cnt",  32'(RS_COUNT), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(OP_RET, 8'h00, 8'h00);
      check("ovf_ret_pc",  32'(PC_OUT),   32'(8'h44 - 8'(i * 16)));
      check("ovf_ret_cnt", 32'(RS_COUNT), 32'(3 - i));
    end
    step(OP_RET, 8'h00, 8'h00);
    check("ovf_ret5_pc",    32'(PC_OUT),   32'h18);
    check("ovf_ret5_empty", 32'(RS_EMPTY), 32'd1);

    // Clear sticky state, then underflow from 0x50.
    @(negedge clock); reset = 1'b1; #2; reset = 1'b0;
`ifdef PC_STACK_ERR_EN
    check("err_clr", 32'(RS_ERR), 32'd0);
`endif
    step(OP_SET, 8'h50, 8'h00);
    step(OP_RET, 8'h00, 8'h00);
    check("unf_pc",  32'(PC_OUT),   32'h54);
    check("unf_cnt", 32'(RS_COUNT), 32'd0);
`ifdef PC_STACK_ERR_EN
    check("unf_err", 32'(RS_ERR), 32'd1);
    step(OP_HOLD, 8'h00, 8'h00);
    check("unf_err_sticky", 32'(RS_ERR), 32'd1);
`endif

    // Asynchronous reset mid-cycle after two pushes.
    step(OP_CALL, 8'h60, 8'h00);
    step(OP_CALL, 8'h70, 8'h00);
    check("pre_rst_cnt", 32'(RS_COUNT), 32'd2);
    PC_OP = OP_HOLD;
    #2; reset = 1'b1; #1;
    check("arst_pc",    32'(PC_OUT),   32'h10);
    check("arst_empty", 32'(RS_EMPTY), 32'd1);
    check("arst_cnt",   32'(RS_COUNT), 32'd0);
`ifdef PC_STACK_ERR_EN
    check("arst_err", 32'(RS_ERR), 32'd0);
`endif
    @(negedge clock); reset = 1'b0;
    step(OP_RET, 8'h00, 8'h00);
    check("post_rst_ret_pc",  32'(PC_OUT),   32'h14);
    check("post_rst_ret_cnt", 32'(RS_COUNT), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
